cripto_stream_ctrl: RTL and testbench

//  Initiator for the 64-bit block cipher core (start/enc_dec/data_i -> busy/ready/data_o, 256-bit key).
//  - Accepts plaintext/ciphertext blocks from an upstream valid/ready stream.
//  - Issues one start pulse per block and waits for the core's ready pulse.
//  - Returns results on a downstream valid/ready stream, with a timeout guard and a block counter.
//  - One block is in flight at a time. The key is wired directly to the core, outside this block.

---
 rtl/cripto_stream_ctrl.sv | 122 ++++++++++++
 tb/tb_cripto_stream_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cripto_stream_ctrl.sv
// rtl/cripto_stream_ctrl.sv - stream initiator for the 64-bit block cipher core, one block in flight.
// Optional CBC chaining is built when CRIPTO_STREAM_CTRL_CBC_EN is defined; otherwise ECB only.
module cripto_stream_ctrl #(
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_enc_dec,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              core_start,
  output logic              core_enc_dec,
  output logic [DATA_W-1:0] core_data,
  input  logic              core_busy,
  input  logic              core_ready,
  input  logic [DATA_W-1:0] core_data_o,
  input  logic [DATA_W-1:0] iv_i,
  input  logic              iv_load,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  blk_count
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tmo_cnt;
  logic              accept, done, tmo;
  logic [DATA_W-1:0] in_blk, result;

  assign accept = s_valid && s_ready;
  assign done   = (state_q == WAIT) && core_ready;
  // core_ready on the final WAIT cycle counts as completion, not timeout
  assign tmo    = (state_q == WAIT) && !core_ready && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef CRIPTO_STREAM_CTRL_CBC_EN
  logic [DATA_W-1:0] chain;

  assign in_blk = cfg_enc_dec ? (s_data ^ chain) : s_data;
  assign result = core_enc_dec ? core_data_o : (core_data_o ^ chain);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chain <= '0;
    end else if ((state_q == IDLE) && iv_load) begin
      chain <= iv_i;
    end else if (done) begin
      chain <= core_enc_dec ? core_data_o : core_data;
    end
  end
`else
  logic unused_cbc;

  assign unused_cbc = ^{iv_i, iv_load};
  assign in_blk     = s_data;
  assign result     = core_data_o;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (done || tmo) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // s_ready is gated by reset so it reads 0 while reset is held
  always_comb begin
    s_ready    = reset && (state_q == IDLE) && !m_valid && !core_busy;
    core_start = (state_q == ISSUE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      core_data    <= '0;
      core_enc_dec <= 1'b0;
      tmo_cnt      <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      blk_count    <= '0;
      err_timeout  <= 1'b0;
    end else begin
      if (accept) begin
        core_data    <= in_blk;
        core_enc_dec <= cfg_enc_dec;
      end
      if (state_q == ISSUE) begin
        tmo_cnt <= '0;
      end else if (state_q == WAIT) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
      if (done) begin
        m_valid   <= 1'b1;
        m_data    <= result;
        blk_count <= blk_count + CNT_W'(1);
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (tmo) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cripto_stream_ctrl.sv
// tb/tb_cripto_stream_ctrl.sv - self-checking bench for cripto_stream_ctrl with a behavioural stub core.
module tb_cripto_stream_ctrl;

  localparam int DATA_W = 64;
  localparam int TMO    = 16;
  localparam int CNT_W  = 4;
  localparam logic [63:0] CORE_KEY = 64'hDEADBEEF01234567;

  logic              clock = 1'b0;
  logic              reset;
  logic              cfg_enc_dec;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic              core_start;
  logic              core_enc_dec;
  logic [DATA_W-1:0] core_data;
  logic              core_busy;
  logic              core_ready;
  logic [DATA_W-1:0] core_data_o;
  logic [DATA_W-1:0] iv_i;
  logic              iv_load;
  logic              err_timeout;
  logic [CNT_W-1:0]  blk_count;

  int n_checks = 0;
  int n_fail   = 0;

  int          mdl_cnt   = 0;
  logic        mdl_err   = 1'b0;
  logic [63:0] mdl_chain = '0;
  logic [63:0] last_exp  = '0;

  int          stub_lat   = 1;
  bit          stub_never = 1'b0;
  int          stub_rem   = 0;
  bit          stub_pend  = 1'b0;
  logic [63:0] stub_res   = '0;

  cripto_stream_ctrl #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .cfg_enc_dec(cfg_enc_dec),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .core_start(core_start), .core_enc_dec(core_enc_dec), .core_data(core_data),
    .core_busy(core_busy), .core_ready(core_ready), .core_data_o(core_data_o),
    .iv_i(iv_i), .iv_load(iv_load), .err_timeout(err_timeout), .blk_count(blk_count)
  );

  always #5 clock = ~clock;

  // Toy invertible cipher: encrypt swaps halves then xors the key; decrypt undoes it
  function automatic logic [63:0] core_fn(input logic [63:0] x, input logic enc);
    logic [63:0] t;
    if (enc) begin
      t = {x[31:0], x[63:32]};
      return t ^ CORE_KEY;
    end
    t = x ^ CORE_KEY;
    return {t[31:0], t[63:32]};
  endfunction

  // Stub core: ready pulses stub_lat cycles after the start pulse; not affected by the controller reset
  always @(posedge clock) begin
    core_ready <= 1'b0;
    if (core_start && !stub_never) begin
      stub_rem  = stub_lat;
      stub_pend = 1'b1;
      stub_res  = core_fn(core_data, core_enc_dec);
      core_busy <= 1'b1;
    end
    if (stub_pend) begin
      if (stub_rem == 1) begin
        core_ready  <= 1'b1;
        core_data_o <= stub_res;
        core_busy   <= 1'b0;
        stub_pend   = 1'b0;
      end else begin
        stub_rem = stub_rem - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one block and runs it to acceptance; returns with the DUT in ISSUE
  task automatic accept_blk(input logic [63:0] d, input logic e, output logic [63:0] cin);
    int w;
    s_data      = d;
    cfg_enc_dec = e;
    s_valid     = 1'b1;
    w = 0;
    while (!s_ready && w < 60) begin
      tick();
      w++;
    end
    check("s_ready_wait", s_ready, 1'b1);
    cin = d;
`ifdef CRIPTO_STREAM_CTRL_CBC_EN
    if (e) cin = d ^ mdl_chain;
`endif
    tick();
    s_valid = 1'b0;
    check("core_start", core_start, 1'b1);
    check("core_data", core_data, cin);
    check("core_enc_dec", core_enc_dec, e);
  endtask

  task automatic send(input logic [63:0] d, input logic e, input int lat, input int hold);
    logic [63:0] cin, exp_out, held;
    int cyc, starts;
    stub_lat   = lat;
    stub_never = 1'b0;
    accept_blk(d, e, cin);
    exp_out = core_fn(cin, e);
`ifdef CRIPTO_STREAM_CTRL_CBC_EN
    if (!e) exp_out = exp_out ^ mdl_chain;
    mdl_chain = e ? exp_out : d;
`endif
    last_exp = exp_out;
    cyc = 1;
    starts = 1;
    while (!m_valid && cyc < 100) begin
      tick();
      cyc++;
      if (core_start) starts++;
    end
    mdl_cnt++;
    check("m_valid", m_valid, 1'b1);
    check("latency", 64'(cyc), 64'(2 + lat));
    check("start_pulses", 64'(starts), 64'd1);
    check("m_data", m_data, exp_out);
    check("blk_count", blk_count, 64'(mdl_cnt % (1 << CNT_W)));
    check("err_timeout", err_timeout, mdl_err);
    held = m_data;
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", m_valid, 1'b1);
      check("hold_data", m_data, held);
      check("hold_s_ready", s_ready, 1'b0);
      tick();
    end
    m_ready = 1'b1;
    check("hs_s_ready", s_ready, 1'b0);
    tick();
    m_ready = 1'b0;
    check("post_hs_valid", m_valid, 1'b0);
    check("post_hs_s_ready", s_ready, 1'b1);
  endtask

  // late_lat = 0: core never answers; otherwise answers late_lat cycles after start
  task automatic timeout_blk(input int late_lat);
    logic [63:0] cin;
    stub_never = (late_lat == 0);
    stub_lat   = late_lat;
    accept_blk({$urandom, $urandom}, 1'b1, cin);
    for (int k = 1; k <= TMO; k++) begin
      tick();
      check("tmo_err_early", err_timeout, mdl_err);
      check("tmo_no_valid", m_valid, 1'b0);
    end
    tick();
    mdl_err = 1'b1;
    check("tmo_err", err_timeout, 1'b1);
    check("tmo_idle", s_ready, 1'b1);
    tick();
    check("tmo_stray_valid", m_valid, 1'b0);
    check("tmo_count", blk_count, 64'(mdl_cnt % (1 << CNT_W)));
  endtask

  initial begin
    logic [63:0] p0, p1, c0, c1;
    reset = 1'b0; cfg_enc_dec = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    iv_i = '0; iv_load = 1'b0;
    core_busy = 1'b0; core_ready = 1'b0; core_data_o = '0;
    repeat (3) tick();
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_core_start", core_start, 1'b0);
    check("rst_core_data", core_data, 64'd0);
    check("rst_err", err_timeout, 1'b0);
    check("rst_count", blk_count, 64'd0);
    reset = 1'b1;
    tick();

    send(64'hA5A5A5A501234567, 1'b1, 3, 0);
    send(core_fn(64'hA5A5A5A501234567, 1'b1), 1'b0, 1, 0);
`ifndef CRIPTO_STREAM_CTRL_CBC_EN
    check("ecb_roundtrip", m_data, 64'hA5A5A5A501234567);
`endif
    send({$urandom, $urandom}, 1'b1, 2, 20);
    for (int n = 0; n < 16; n++) begin
      send({$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom_range(1, TMO - 1),
           $urandom_range(0, 3));
    end
    send({$urandom, $urandom}, 1'b1, TMO, 1);

    timeout_blk(0);
    timeout_blk(TMO + 1);
    send({$urandom, $urandom}, 1'b0, 4, 0);

    // Reset in the middle of WAIT, stray core_ready arrives after release
    stub_lat = 10;
    stub_never = 1'b0;
    accept_blk({$urandom, $urandom}, 1'b1, c0);
    repeat (4) tick();
    reset = 1'b0;
    #1;
    check("mid_rst_s_ready", s_ready, 1'b0);
    check("mid_rst_m_data", m_data, 64'd0);
    check("mid_rst_core_start", core_start, 1'b0);
    check("mid_rst_core_enc_dec", core_enc_dec, 1'b0);
    check("mid_rst_core_data", core_data, 64'd0);
    check("mid_rst_err", err_timeout, 1'b0);
    check("mid_rst_count", blk_count, 64'd0);
    mdl_cnt = 0; mdl_err = 1'b0; mdl_chain = '0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("stray_no_valid", m_valid, 1'b0);
    end
    check("stray_count", blk_count, 64'd0);
    send({$urandom, $urandom}, 1'b1, 5, 0);

`ifdef CRIPTO_STREAM_CTRL_CBC_EN
    iv_i = '0; iv_load = 1'b1; tick(); iv_load = 1'b0; mdl_chain = '0;
    p0 = {$urandom, $urandom};
    p1 = {$urandom, $urandom};
    send(p0, 1'b1, 3, 0); c0 = last_exp;
    send(p1, 1'b1, 2, 0); c1 = last_exp;
    iv_i = '0; iv_load = 1'b1; tick(); iv_load = 1'b0; mdl_chain = '0;
    send(c0, 1'b0, 2, 0);
    check("cbc_p0", m_data, p0);
    send(c1, 1'b0, 3, 0);
    check("cbc_p1", m_data, p1);
`else
    p0 = '0; p1 = '0; c1 = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
